// File: rtl/common_pkg.sv
// Shared NoC constants, the default packet layout and a packet-width helper.
// Imported by noc_delay_line and noc_credit_pipe.
package common_pkg;

   localparam int DEFAULT_VC_W = 2;
   localparam int DEFAULT_A_W  = 4;
   localparam int DEFAULT_D_W  = 32;
   localparam int DEFAULT_N    = 4;

   // Address sits in the MSBs so a packed packet_t matches the flat link bus.
   typedef struct packed {
      logic [DEFAULT_A_W-1:0] addr;
      logic [DEFAULT_D_W-1:0] data;
   } packet_t;

   function automatic int pkt_w(input int a_w, input int d_w);
      return a_w + d_w;
   endfunction

endpackage

// File: rtl/noc_delay_line.sv
// Generic LATENCY-deep shift register with asynchronous active-high reset to zero.
// LATENCY=0 is a plain wire; clk and rst are then unused.
module noc_delay_line
   import common_pkg::*;
#(
   parameter int WIDTH   = 1,
   parameter int LATENCY = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (LATENCY == 0) begin : g_wire
         assign dout = din;
         logic unused_ok;
         assign unused_ok = clk ^ rst;
      end else begin : g_pipe
         logic [LATENCY-1:0][WIDTH-1:0] stage;

         // NOTE: every stage is reset, not just the last one: a reset must discard all
         // in-flight flits/credits, otherwise stale entries would emerge after release.
         // NOTE: state is written with non-blocking assignments so each stage samples the
         // previous stage's pre-edge value, giving exactly one cycle of delay per stage.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               stage <= '0;
            end else begin
               stage[0] <= din;
               for (int i = 1; i < LATENCY; i++) begin
                  stage[i] <= stage[i-1];
               end
            end
         end

         assign dout = stage[LATENCY-1];
      end
   endgenerate

endmodule

// File: rtl/noc_credit_pipe.sv
// Register slice for one credit-flow-controlled NoC link: flits forward, per-VC credits back.
// Optional protocol checker enabled by defining NOC_PIPE_CHECK_EN.
module noc_credit_pipe
   import common_pkg::*;
#(
   parameter int VC_W    = DEFAULT_VC_W,
   parameter int A_W     = 4,
   parameter int D_W     = DEFAULT_D_W,
   parameter int LATENCY = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [VC_W-1:0]      from_vc_target,
   input  logic [A_W+D_W-1:0]   from_packet,
   output logic [VC_W-1:0]      from_credit_gnt,
   output logic [VC_W-1:0]      to_vc_target,
   output logic [A_W+D_W-1:0]   to_packet,
   input  logic [VC_W-1:0]      to_credit_gnt,
   output logic                 check_err
);

   localparam int PKT_W = pkt_w(A_W, D_W);
   localparam int FWD_W = VC_W + PKT_W;

   generate
      if (VC_W < 1) begin : g_bad_vc_w
         $fatal(1, "noc_credit_pipe: VC_W must be > 0");
      end
      if (A_W < 1) begin : g_bad_a_w
         $fatal(1, "noc_credit_pipe: A_W must be > 0");
      end
      if (D_W < 1) begin : g_bad_d_w
         $fatal(1, "noc_credit_pipe: D_W must be > 0");
      end
      if (LATENCY < 0) begin : g_bad_latency
         $fatal(1, "noc_credit_pipe: LATENCY must be >= 0");
      end
   endgenerate

   logic [FWD_W-1:0] fwd_in;
   logic [FWD_W-1:0] fwd_out;

   // Payload travels with its valid bits so both always share the same delay.
   assign fwd_in = {from_vc_target, from_packet};

   noc_delay_line #(
      .WIDTH   (FWD_W),
      .LATENCY (LATENCY)
   ) u_fwd (
      .clk  (clk),
      .rst  (rst),
      .din  (fwd_in),
      .dout (fwd_out)
   );

   assign to_vc_target = fwd_out[FWD_W-1 -: VC_W];
   assign to_packet    = fwd_out[PKT_W-1:0];

   noc_delay_line #(
      .WIDTH   (VC_W),
      .LATENCY (LATENCY)
   ) u_rev (
      .clk  (clk),
      .rst  (rst),
      .din  (to_credit_gnt),
      .dout (from_credit_gnt)
   );

`ifdef NOC_PIPE_CHECK_EN
   logic violation;

   // Inputs are checked before the delay lines so LATENCY=0 is covered too.
   always_comb begin
      violation = ($countones(from_vc_target) > 1) || ($countones(to_credit_gnt) > 1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         check_err <= 1'b0;
      end else if (violation) begin
         check_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && violation) begin
         $error("noc_credit_pipe: multi-hot vc_target=%b credit_gnt=%b",
                from_vc_target, to_credit_gnt);
      end
   end
`else
   assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_credit_pipe.sv
// Scoreboard bench for noc_credit_pipe at LATENCY 0, 2 and 3 driven with the same link traffic.
// Expected outputs come from per-instance delay queues built from the link's delay/reset rules.
module tb_noc_credit_pipe;
   import common_pkg::*;

   localparam int VC_W  = 2;
   localparam int A_W   = 4;
   localparam int D_W   = 32;
   localparam int PW    = A_W + D_W;
   localparam int NCYC  = 200;
   localparam int L0    = 0;
   localparam int L2    = 2;
   localparam int L3    = 3;

   typedef struct packed {
      logic [VC_W-1:0] vc;
      logic [PW-1:0]   pkt;
      logic [VC_W-1:0] cred;
   } sample_t;

   logic            clk;
   logic            rst;
   logic [VC_W-1:0] from_vc_target;
   logic [PW-1:0]   from_packet;
   logic [VC_W-1:0] to_credit_gnt;

   logic [VC_W-1:0] o0_vc, o2_vc, o3_vc;
   logic [PW-1:0]   o0_pkt, o2_pkt, o3_pkt;
   logic [VC_W-1:0] o0_cred, o2_cred, o3_cred;
   logic            o0_err, o2_err, o3_err;

   int checks   = 0;
   int failures = 0;

   sample_t q0[$];
   sample_t q2[$];
   sample_t q3[$];
   logic    err_now  = 1'b0;
   logic    err_next = 1'b0;

   noc_credit_pipe #(.VC_W(VC_W), .A_W(A_W), .D_W(D_W), .LATENCY(L0)) dut0 (
      .clk(clk), .rst(rst),
      .from_vc_target(from_vc_target), .from_packet(from_packet), .from_credit_gnt(o0_cred),
      .to_vc_target(o0_vc), .to_packet(o0_pkt), .to_credit_gnt(to_credit_gnt),
      .check_err(o0_err)
   );

   noc_credit_pipe #(.VC_W(VC_W), .A_W(A_W), .D_W(D_W), .LATENCY(L2)) dut2 (
      .clk(clk), .rst(rst),
      .from_vc_target(from_vc_target), .from_packet(from_packet), .from_credit_gnt(o2_cred),
      .to_vc_target(o2_vc), .to_packet(o2_pkt), .to_credit_gnt(to_credit_gnt),
      .check_err(o2_err)
   );

   noc_credit_pipe #(.VC_W(VC_W), .A_W(A_W), .D_W(D_W), .LATENCY(L3)) dut3 (
      .clk(clk), .rst(rst),
      .from_vc_target(from_vc_target), .from_packet(from_packet), .from_credit_gnt(o3_cred),
      .to_vc_target(o3_vc), .to_packet(o3_pkt), .to_credit_gnt(to_credit_gnt),
      .check_err(o3_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic multi_hot(input logic [VC_W-1:0] v);
      return $countones(v) > 1;
   endfunction

   // A cycle touched by reset: every stage reads zero now, and the input of this
   // cycle is the first thing captured once reset is released before the next edge.
   task automatic model_push(input sample_t s, input bit rst_cycle);
      if (rst_cycle) begin
         q2.delete();
         q3.delete();
         repeat (L2) q2.push_back('0);
         repeat (L3) q3.push_back('0);
      end
      q0.push_back(s);
      q2.push_back(s);
      q3.push_back(s);
      err_now  = rst_cycle ? 1'b0 : err_next;
      err_next = err_now | multi_hot(s.vc) | multi_hot(s.cred);
   endtask

   function automatic sample_t pick(input int c);
      sample_t s;
      packet_t p;
      s.vc   = VC_W'($urandom_range(0, 2));
      s.pkt  = {A_W'($urandom), 32'($urandom)};
      s.cred = VC_W'($urandom_range(0, 2));
      case (c)
         0, 1: s = '0;
         2: begin
            p.addr = 4'hA;
            p.data = 32'hDEAD_BEEF;
            s.vc = 2'b01; s.pkt = p; s.cred = 2'b10;
         end
         4, 6: begin s.vc = 2'b00; s.cred = 2'b00; end
         5:    begin s.vc = 2'b10; s.cred = 2'b00; end
         8:    begin s.vc = 2'b01; s.pkt = 36'd1; end
         9:    begin s.vc = 2'b01; s.pkt = 36'd2; end
         10:   begin s.vc = 2'b01; s.pkt = 36'd3; end
         11:   begin s.vc = 2'b00; s.cred = 2'b01; end
         13:   begin s.vc = 2'b10; s.cred = 2'b01; end
         20:   s.vc = 2'b11;
         25:   s.cred = 2'b11;
         default: ;
      endcase
      return s;
   endfunction

   function automatic logic exp_err();
`ifdef NOC_PIPE_CHECK_EN
      return err_now;
`else
      return 1'b0;
`endif
   endfunction

   // Monitor: each negedge, one entry per instance belongs to the current cycle.
   initial begin
      sample_t e;
      forever begin
         @(negedge clk);
         if (q0.size() > L0) begin
            e = q0.pop_front();
            check("l0_vc",   64'(o0_vc),   64'(e.vc));
            check("l0_pkt",  64'(o0_pkt),  64'(e.pkt));
            check("l0_cred", 64'(o0_cred), 64'(e.cred));
            check("l0_err",  64'(o0_err),  64'(exp_err()));
         end
         if (q2.size() > L2) begin
            e = q2.pop_front();
            check("l2_vc",   64'(o2_vc),   64'(e.vc));
            check("l2_pkt",  64'(o2_pkt),  64'(e.pkt));
            check("l2_cred", 64'(o2_cred), 64'(e.cred));
            check("l2_err",  64'(o2_err),  64'(exp_err()));
         end
         if (q3.size() > L3) begin
            e = q3.pop_front();
            check("l3_vc",   64'(o3_vc),   64'(e.vc));
            check("l3_pkt",  64'(o3_pkt),  64'(e.pkt));
            check("l3_cred", 64'(o3_cred), 64'(e.cred));
            check("l3_err",  64'(o3_err),  64'(exp_err()));
         end
      end
   end

   initial begin
      sample_t s;
      bit      rcyc;
      rst            = 1'b1;
      from_vc_target = '0;
      from_packet    = '0;
      to_credit_gnt  = '0;
      for (int c = 0; c < NCYC; c++) begin
         @(posedge clk);
         #1;
         s              = pick(c);
         from_vc_target = s.vc;
         from_packet    = s.pkt;
         to_credit_gnt  = s.cred;
         rcyc           = (c < 2);
         if (c == 14 || c == 60 || c == 61 || c == 150) begin
            #1 rst = 1'b1;
            rcyc = 1'b1;
            #1;
            check("rst_async_l2_vc", 64'(o2_vc), 64'd0);
            check("rst_async_l3_vc", 64'(o3_vc), 64'd0);
            check("rst_async_l0_vc", 64'(o0_vc), 64'(s.vc));
            if (c != 60) begin
               #1 rst = 1'b0;
            end
         end
         if (c == 1) begin
            #3 rst = 1'b0;
         end
         model_push(s, rcyc);
      end
      @(negedge clk);
      #1;
      check("q0_drained", 64'(q0.size()), 64'(L0));
      check("q3_drained", 64'(q3.size()), 64'(L3));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
